// File: rtl/lower_level_mem_responder_pkg.sv
// Shared types and defaults for the lower-level memory responder.
package has3_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_ARB,
    RD_DRIVE,
    WR_WAIT,
    WR_DONE
  } state_e;

  localparam int unsigned DEF_RD_LATENCY = 4;
  localparam int unsigned DEF_WR_LATENCY = 4;

  // Counter must hold max(RD_LATENCY, WR_LATENCY)-1 with one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned rd_lat, input int unsigned wr_lat);
    int unsigned max_lat;
    max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return $clog2(max_lat) + 1;
  endfunction

endpackage

// File: rtl/lower_level_mem_responder_if.sv
// Shared-bus signals between the cache side (master) and the memory responder (slave).
interface lower_level_mem_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              BusRd;
  logic              BusRdX;
  logic              Mem_wr;
  logic              Mem_oprn_abort;
  logic [ADDR_W-1:0] Address_Com;
  logic [DATA_W-1:0] Data_Bus_Com_in;
  logic [DATA_W-1:0] Data_Bus_Com_out;
  logic              Data_Bus_Com_oe;
  logic              Data_in_Bus;
  logic              Mem_write_done;
  logic              Mem_snoop_req;
  logic              Mem_snoop_gnt;

  modport master (
    output BusRd, BusRdX, Mem_wr, Mem_oprn_abort, Address_Com, Data_Bus_Com_in, Mem_snoop_gnt,
    input  Data_Bus_Com_out, Data_Bus_Com_oe, Data_in_Bus, Mem_write_done, Mem_snoop_req
  );

  modport slave (
    input  BusRd, BusRdX, Mem_wr, Mem_oprn_abort, Address_Com, Data_Bus_Com_in, Mem_snoop_gnt,
    output Data_Bus_Com_out, Data_Bus_Com_oe, Data_in_Bus, Mem_write_done, Mem_snoop_req
  );

endinterface

// File: rtl/lower_level_mem_responder_mem_storage_array.sv
// Word storage with per-word valid bits; unwritten words read back as the
// zero-extended request address.
module mem_storage_array #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_W-1:0]     rdata_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH_LOG2-1:0] ridx;

  assign ridx = raddr_i[DEPTH_LOG2+1:2];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    valid_q          <= '0;
    else if (we_i) valid_q[waddr_i] <= 1'b1;
  end

  assign rdata_c = valid_q[ridx] ? mem_q[ridx] : DATA_W'(raddr_i);

endmodule

// File: rtl/lower_level_mem_responder.sv
// Memory-side bus responder: latency-delayed line fills with bus arbitration,
// delayed write-backs, and abort of in-flight reads when a cache supplies the line.
module lower_level_mem_responder
  import has3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY,
  parameter int unsigned WR_LATENCY = DEF_WR_LATENCY
) (
  input logic                         clk,
  input logic                         rst_n,
  lower_level_mem_responder_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(RD_LATENCY, WR_LATENCY);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              req_q, req_d;
  logic              din_q, din_d;
  logic              oe_q, oe_d;
  logic              done_q, done_d;
  logic              we_c;
  logic [DATA_W-1:0] rd_word_c;
  logic              rd_req_c;

  assign rd_req_c = bus.BusRd | bus.BusRdX;

  mem_storage_array #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we_c),
    .waddr_i (addr_q[DEPTH_LOG2+1:2]),
    .wdata_i (wdata_q),
    .raddr_i (addr_q),
    .rdata_c (rd_word_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      req_q   <= 1'b0;
      din_q   <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      req_q   <= req_d;
      din_q   <= din_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Mem_wr) begin
          addr_d  = bus.Address_Com;
          wdata_d = bus.Data_Bus_Com_in;
          cnt_d   = CNT_W'(WR_LATENCY - 1);
          state_d = WR_WAIT;
        end else if (rd_req_c) begin
          addr_d  = bus.Address_Com;
          cnt_d   = CNT_W'(RD_LATENCY - 1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.Mem_oprn_abort)  state_d = IDLE;
        else if (cnt_q == '0)    state_d = RD_ARB;
        else                     cnt_d   = cnt_q - CNT_W'(1);
      end
      RD_ARB: begin
        if (bus.Mem_oprn_abort)     state_d = IDLE;
        else if (bus.Mem_snoop_gnt) state_d = RD_DRIVE;
      end
      RD_DRIVE: begin
        if (bus.Mem_oprn_abort || !rd_req_c) state_d = IDLE;
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          we_c    = 1'b1;
          state_d = WR_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_DONE: begin
        if (!bus.Mem_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_d  = (state_d == RD_ARB) || (state_d == RD_DRIVE);
    din_d  = (state_d == RD_DRIVE);
    oe_d   = (state_d == RD_DRIVE);
    done_d = (state_d == WR_DONE);
    dout_d = (state_d == RD_DRIVE) ? rd_word_c : '0;
  end

  assign bus.Mem_snoop_req    = req_q;
  assign bus.Data_in_Bus      = din_q;
  assign bus.Data_Bus_Com_oe  = oe_q;
  assign bus.Data_Bus_Com_out = dout_q;
  assign bus.Mem_write_done   = done_q;

endmodule

// File: tb/tb_lower_level_mem_responder.sv
// Scoreboard bench: stimulus queues expected bus events with their cycle; a
// negedge monitor pops and compares on each rising response strobe.
module tb_lower_level_mem_responder;

  typedef enum int {EV_REQ, EV_RD, EV_WR} ev_e;
  typedef struct {
    ev_e         kind;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic req_p = 1'b0, din_p = 1'b0, done_p = 1'b0;

  lower_level_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  lower_level_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(10), .RD_LATENCY(4), .WR_LATENCY(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1);
  end

  task automatic mon_event(input ev_e k, input logic [31:0] d);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d data=%h required no event", k, cyc, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc ||
          (k == EV_RD && (d !== e.data || bus_if.Data_Bus_Com_oe !== 1'b1))) begin
        errors++;
        $display("FAIL event actual kind=%0d cyc=%0d data=%h oe=%b required kind=%0d cyc=%0d data=%h",
                 k, cyc, d, bus_if.Data_Bus_Com_oe, e.kind, e.cyc, e.data);
      end
    end
  endtask

  // Monitor: every rising strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus_if.Mem_snoop_req && !req_p)  mon_event(EV_REQ, 32'h0);
    if (bus_if.Data_in_Bus && !din_p)    mon_event(EV_RD, bus_if.Data_Bus_Com_out);
    if (bus_if.Mem_write_done && !done_p) mon_event(EV_WR, 32'h0);
    req_p  <= bus_if.Mem_snoop_req;
    din_p  <= bus_if.Data_in_Bus;
    done_p <= bus_if.Mem_write_done;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_strobes"}, {28'h0, bus_if.Mem_snoop_req, bus_if.Data_in_Bus,
                             bus_if.Data_Bus_Com_oe, bus_if.Mem_write_done}, 32'h0);
    chk({name, "_dout"}, bus_if.Data_Bus_Com_out, 32'h0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic read_txn(input logic [31:0] addr, input bit rdx, input logic [31:0] exp, input int gw);
    int t;
    @(negedge clk);
    bus_if.Address_Com = addr;
    bus_if.BusRd       = ~rdx;
    bus_if.BusRdX      = rdx;
    if (gw > 0) bus_if.Mem_snoop_gnt = 1'b0;
    t = cyc + 1;
    exp_q.push_back('{EV_REQ, 32'h0, t + 4});
    exp_q.push_back('{EV_RD, exp, t + 5 + gw});
    for (int c = t + 5; c <= t + 4 + gw; c++) begin
      wait_cyc(c);
      chk("grant_wait", {30'h0, bus_if.Mem_snoop_req, bus_if.Data_in_Bus}, 32'h2);
    end
    if (gw > 0) bus_if.Mem_snoop_gnt = 1'b1;
    wait_cyc(t + 5 + gw);
    bus_if.BusRd  = 1'b0;
    bus_if.BusRdX = 1'b0;
    @(negedge clk);
    chk_idle("read_release");
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data);
    int t;
    @(negedge clk);
    bus_if.Address_Com     = addr;
    bus_if.Data_Bus_Com_in = data;
    bus_if.Mem_wr          = 1'b1;
    t = cyc + 1;
    exp_q.push_back('{EV_WR, 32'h0, t + 4});
    wait_cyc(t + 4);
    bus_if.Mem_wr = 1'b0;
    @(negedge clk);
    chk("write_release_done", {31'h0, bus_if.Mem_write_done}, 32'h0);
  endtask

  initial begin
    int t;
    rst_n                  = 1'b0;
    bus_if.BusRd           = 1'b0;
    bus_if.BusRdX          = 1'b0;
    bus_if.Mem_wr          = 1'b0;
    bus_if.Mem_oprn_abort  = 1'b0;
    bus_if.Address_Com     = 32'h0;
    bus_if.Data_Bus_Com_in = 32'h0;
    bus_if.Mem_snoop_gnt   = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

    // Cold read, write-back then RFO read, aliasing and fill with byte offset.
    read_txn(32'h0000_0040, 1'b0, 32'h0000_0040, 0);
    write_txn(32'h0000_0080, 32'hDEAD_BEEF);
    read_txn(32'h0000_0080, 1'b1, 32'hDEAD_BEEF, 0);
    read_txn(32'h0000_1083, 1'b0, 32'hDEAD_BEEF, 0);
    read_txn(32'h0000_0047, 1'b0, 32'h0000_0047, 0);

    // Grant held low for three sampled cycles in arbitration.
    read_txn(32'h0000_0080, 1'b0, 32'hDEAD_BEEF, 3);

    // Abort while waiting on latency: no request may ever appear.
    @(negedge clk);
    bus_if.Address_Com = 32'h0000_0200;
    bus_if.BusRd       = 1'b1;
    t = cyc + 1;
    wait_cyc(t + 1);
    bus_if.Mem_oprn_abort = 1'b1;
    bus_if.BusRd          = 1'b0;
    @(negedge clk);
    bus_if.Mem_oprn_abort = 1'b0;
    chk_idle("abort_wait");
    repeat (8) @(negedge clk);

    // Abort while driving data, then a normal write-back and read of it.
    @(negedge clk);
    bus_if.Address_Com = 32'h0000_0080;
    bus_if.BusRd       = 1'b1;
    t = cyc + 1;
    exp_q.push_back('{EV_REQ, 32'h0, t + 4});
    exp_q.push_back('{EV_RD, 32'hDEAD_BEEF, t + 5});
    wait_cyc(t + 5);
    bus_if.Mem_oprn_abort = 1'b1;
    @(negedge clk);
    chk_idle("abort_drive");
    bus_if.BusRd          = 1'b0;
    bus_if.Mem_oprn_abort = 1'b0;
    write_txn(32'h0000_0300, 32'h0BAD_F00D);
    read_txn(32'h0000_0300, 1'b0, 32'h0BAD_F00D, 0);

    // Simultaneous write and read: write first, read then returns new data.
    @(negedge clk);
    bus_if.Address_Com     = 32'h0000_0100;
    bus_if.Data_Bus_Com_in = 32'h1234_5678;
    bus_if.Mem_wr          = 1'b1;
    bus_if.BusRd           = 1'b1;
    t = cyc + 1;
    exp_q.push_back('{EV_WR, 32'h0, t + 4});
    exp_q.push_back('{EV_REQ, 32'h0, t + 10});
    exp_q.push_back('{EV_RD, 32'h1234_5678, t + 11});
    wait_cyc(t + 4);
    bus_if.Mem_wr = 1'b0;
    wait_cyc(t + 5);
    chk("simul_done_drop", {31'h0, bus_if.Mem_write_done}, 32'h0);
    wait_cyc(t + 11);
    bus_if.BusRd = 1'b0;
    @(negedge clk);
    chk_idle("simul_release");

    // Reset while a read is on the bus: outputs clear without a clock edge.
    @(negedge clk);
    bus_if.Address_Com = 32'h0000_0040;
    bus_if.BusRd       = 1'b1;
    t = cyc + 1;
    exp_q.push_back('{EV_REQ, 32'h0, t + 4});
    exp_q.push_back('{EV_RD, 32'h0000_0040, t + 5});
    wait_cyc(t + 5);
    #2 rst_n = 1'b0;
    #1 chk_idle("reset_drive");
    bus_if.BusRd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during write latency: write discarded, no done, fill reads back.
    @(negedge clk);
    bus_if.Address_Com     = 32'h0000_00C0;
    bus_if.Data_Bus_Com_in = 32'hAAAA_5555;
    bus_if.Mem_wr          = 1'b1;
    t = cyc + 1;
    wait_cyc(t + 2);
    rst_n = 1'b0;
    #1 chk_idle("reset_write");
    bus_if.Mem_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    read_txn(32'h0000_00C0, 1'b0, 32'h0000_00C0, 0);
    read_txn(32'h0000_0080, 1'b0, 32'h0000_0080, 0);

    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
